pipe_skid_stage: RTL and testbench

Parametrised, flow-controlled pipeline stage register for the five-stage MIPS datapath. It replaces the fixed-field, always-advancing inter-stage registers with a generic multi-lane register. The register has a valid/ready handshake, a two-entry skid buffer so that `in_ready` is driven from a flop, and a synchronous flush for branch and exception squash. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance carries `LANES` fields of `WIDTH` bits, for example PC, PC+8, IR, RD2, ALU result and MUL/DIV result.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_skid_stage_if.sv | 18 +
 rtl/pipe_sat_counter.sv | 26 ++
 rtl/pipe_skid_stage.sv | 114 +++++++++++
 tb/tb_pipe_skid_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the flow-controlled pipeline stage register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Occupancy of a stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  localparam int          PIPE_WIDTH     = 32;
  localparam logic [31:0] PIPE_RESET_VAL = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready bus carrying LANES packed fields of WIDTH bits between stages.
// Latency: n/a (wires only).
// Backpressure: master holds valid/data until the slave raises ready.
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int LANES = 7,
  parameter int WIDTH = PIPE_WIDTH
);

  logic                   valid;
  logic                   ready;
  logic [LANES*WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with increment enable; cleared only by reset.
// Latency: count reflects an increment one edge after i_inc is sampled.
// Backpressure: none; sticks at all-ones once reached.
module pipe_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Count enabled cycles, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_stage.sv
// Multi-lane pipeline stage register with a two-entry skid buffer and flush; PIPE_SKID_STALL_CNT_EN adds stall_cnt.
// Latency: data accepted at edge N is on o_dn.data after edge N (one cycle).
// Backpressure: i_up.ready is registered; one extra entry is absorbed in the skid register.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int          LANES     = 7,
  parameter int          WIDTH     = PIPE_WIDTH,
  parameter logic [31:0] RESET_VAL = PIPE_RESET_VAL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_skid_stage_if.slave        i_up,
  pipe_skid_stage_if.master       o_dn
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int               DW       = LANES * WIDTH;
  localparam logic [WIDTH-1:0] RST_LANE = WIDTH'(RESET_VAL);
  localparam logic [DW-1:0]    RST_DATA = {LANES{RST_LANE}};

  pipe_state_t   r_state;
  pipe_state_t   w_state_nxt;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic [DW-1:0] w_main_nxt;
  logic [DW-1:0] w_skid_nxt;
  logic          r_in_ready;
  logic          w_in_ready_nxt;
  logic          w_out_valid;
  logic          w_in_fire;
  logic          w_out_fire;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = i_up.valid & r_in_ready;
  assign w_out_fire  = w_out_valid & o_dn.ready;

  assign i_up.ready  = r_in_ready;
  assign o_dn.valid  = w_out_valid;
  assign o_dn.data   = r_main;

  // Next occupancy and storage contents; flush squashes both entries and any same-cycle transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RST_DATA;
      w_skid_nxt  = RST_DATA;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = i_up.data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = i_up.data;
          end else if (w_in_fire) begin
            w_skid_nxt  = i_up.data;
            w_state_nxt = ST_TWO;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Input is never accepted here because ready is low while full.
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
    w_in_ready_nxt = (w_state_nxt != ST_TWO);
  end

  // State, storage and registered ready; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= RST_DATA;
      r_skid     <= RST_DATA;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= w_in_ready_nxt;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  pipe_sat_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_out_valid & ~o_dn.ready),
    .o_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based occupancy model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int L  = 7;
  localparam int W  = 32;
  localparam int DW = L * W;
  localparam logic [DW-1:0] RST_ALL = '0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic flush2 = 1'b0;
  bit   chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.LANES(L), .WIDTH(W)) u_up ();
  pipe_skid_stage_if #(.LANES(L), .WIDTH(W)) u_dn ();
  pipe_skid_stage_if #(.LANES(2), .WIDTH(8)) u_up2 ();
  pipe_skid_stage_if #(.LANES(2), .WIDTH(8)) u_dn2 ();

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_cnt2;
  logic        sat_inc = 1'b0;
  logic [2:0]  sat_cnt;

  pipe_sat_counter #(.WIDTH(3)) u_sat (
    .clk(clk), .reset(reset), .i_inc(sat_inc), .o_cnt(sat_cnt)
  );
`endif

  pipe_skid_stage #(.LANES(L), .WIDTH(W), .RESET_VAL(32'h0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .i_up(u_up), .o_dn(u_dn)
`ifdef PIPE_SKID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pipe_skid_stage #(.LANES(2), .WIDTH(8), .RESET_VAL(32'h1234_56A5)) dut2 (
    .clk(clk), .reset(reset), .flush(flush2), .i_up(u_up2), .o_dn(u_dn2)
`ifdef PIPE_SKID_STALL_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Lane 0 carries the tag; other lanes are distinct derivatives so lane swaps show up.
  function automatic logic [DW-1:0] mk(input logic [31:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < L; k++) r[k*W +: W] = v ^ (32'(k) << 24);
    return r;
  endfunction

  // Model: a FIFO of at most two entries; ready is simply "fewer than two held".
  logic [DW-1:0] mq[$];
  bit            m_rdy = 1'b1;
  bit            m_idle_known = 1'b1;
  logic [31:0]   m_stall = '0;
  logic [31:0]   dut_log[$];

  initial forever begin : model
    bit of_, if_;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_rdy = 1'b1;
      m_idle_known = 1'b1;
      m_stall = '0;
    end else begin
      if (mq.size() > 0 && !u_dn.ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) begin
        mq.delete();
        m_rdy = 1'b1;
        m_idle_known = 1'b1;
      end else begin
        of_ = (mq.size() > 0) && u_dn.ready;
        if_ = u_up.valid && m_rdy;
        if (of_) begin
          void'(mq.pop_front());
          m_idle_known = 1'b0;
        end
        if (if_) mq.push_back(u_up.data);
        m_rdy = (mq.size() < 2);
      end
    end
  end

  // Per-cycle comparison, away from the active edge; also logs what the DUT hands downstream.
  initial forever begin : compare
    @(negedge clk);
    if (chk_en) begin
      chk("out_valid", DW'(u_dn.valid), DW'(mq.size() > 0));
      chk("in_ready", DW'(u_up.ready), DW'(m_rdy));
      if (mq.size() > 0) chk("out_data", u_dn.data, mq[0]);
      else if (m_idle_known) chk("idle_data", u_dn.data, RST_ALL);
`ifdef PIPE_SKID_STALL_CNT_EN
      chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
`endif
      if (u_dn.valid && u_dn.ready) dut_log.push_back(u_dn.data[31:0]);
    end
  end

  task automatic step(input bit v, input logic [31:0] d0, input bit ordy, input bit fl);
    u_up.valid = v;
    u_up.data  = mk(d0);
    u_dn.ready = ordy;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    u_up.valid  = 1'b0;
    u_up.data   = '0;
    u_dn.ready  = 1'b0;
    u_up2.valid = 1'b0;
    u_up2.data  = '0;
    u_dn2.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset values.
    chk("rst_out_valid", DW'(u_dn.valid), DW'(0));
    chk("rst_in_ready", DW'(u_up.ready), DW'(1));
    chk("rst_out_data", u_dn.data, RST_ALL);
    chk("rst_w8_data", DW'(u_dn2.data), DW'(16'hA5A5));
`ifdef PIPE_SKID_STALL_CNT_EN
    chk("rst_stall_cnt", DW'(stall_cnt), DW'(0));
`endif

    // Streaming: eight words at full rate.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
      if (i == 0) begin
        chk("stream_first_valid", DW'(u_dn.valid), DW'(1));
        chk("stream_first_lane0", DW'(u_dn.data[31:0]), DW'(32'h100));
        chk("stream_first_lane6", DW'(u_dn.data[6*32 +: 32]), DW'(32'h0600_0100));
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_count", DW'(dut_log.size()), DW'(8));
    for (int i = 0; i < 8 && i < dut_log.size(); i++)
      chk("stream_order", DW'(dut_log[i]), DW'(32'h100 + 32'(i)));
    dut_log.delete();

    // Backpressure: A and B absorbed, C held off until release.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    chk("bp_ready_after_A", DW'(u_up.ready), DW'(1));
    step(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_ready_full", DW'(u_up.ready), DW'(0));
    chk("bp_head_A", DW'(u_dn.data[31:0]), DW'(32'hA));
    step(1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_head_held", DW'(u_dn.data[31:0]), DW'(32'hA));
    chk("bp_still_full", DW'(u_up.ready), DW'(0));
    step(1'b1, 32'hC, 1'b1, 1'b0);
    chk("bp_ready_back", DW'(u_up.ready), DW'(1));
    chk("bp_head_B", DW'(u_dn.data[31:0]), DW'(32'hB));
    step(1'b1, 32'hC, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_count", DW'(dut_log.size()), DW'(3));
    if (dut_log.size() == 3) begin
      chk("bp_order0", DW'(dut_log[0]), DW'(32'hA));
      chk("bp_order1", DW'(dut_log[1]), DW'(32'hB));
      chk("bp_order2", DW'(dut_log[2]), DW'(32'hC));
    end
    dut_log.delete();

    // Flush while full, with a same-cycle push of D.
    step(1'b1, 32'hE, 1'b0, 1'b0);
    step(1'b1, 32'hF, 1'b0, 1'b0);
    step(1'b1, 32'hD, 1'b0, 1'b1);
    chk("flush_valid", DW'(u_dn.valid), DW'(0));
    chk("flush_data", u_dn.data, RST_ALL);
    chk("flush_ready", DW'(u_up.ready), DW'(1));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_nothing_out", DW'(dut_log.size()), DW'(0));
    dut_log.delete();

    // Reset while full, flush low.
    step(1'b1, 32'h55, 1'b0, 1'b0);
    step(1'b1, 32'h66, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 32'h77, 1'b0, 1'b0);
    reset = 1'b0;
    chk("rstmid_valid", DW'(u_dn.valid), DW'(0));
    chk("rstmid_ready", DW'(u_up.ready), DW'(1));
    chk("rstmid_data", u_dn.data, RST_ALL);
`ifdef PIPE_SKID_STALL_CNT_EN
    chk("rstmid_stall", DW'(stall_cnt), DW'(0));

    // Stall counter: five stalled valid cycles, then a flush that must not clear it.
    step(1'b1, 32'h88, 1'b0, 1'b0);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_five", DW'(stall_cnt), DW'(5));
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_after_flush", DW'(stall_cnt), DW'(5));

    // Saturation on a narrow counter.
    sat_inc = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    sat_inc = 1'b0;
    chk("sat_hold", DW'(sat_cnt), DW'(3'h7));
`endif

    // Narrow instance: two 8-bit lanes.
    u_up2.valid = 1'b1;
    u_up2.data  = 16'hBEEF;
    @(posedge clk);
    #1;
    u_up2.valid = 1'b0;
    chk("w8_valid", DW'(u_dn2.valid), DW'(1));
    chk("w8_data", DW'(u_dn2.data), DW'(16'hBEEF));
    chk("w8_lane1", DW'(u_dn2.data[15:8]), DW'(8'hBE));
    @(posedge clk);
    #1;
    chk("w8_drained", DW'(u_dn2.valid), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
